// File: rtl/trellis_decoder.sv
// ============================================================================
// Module   : trellis_decoder
// Purpose  : Inverts the serial-bit encoder FSM with one symbol of look-ahead,
//            flags illegal symbols and resynchronises after an error.
//            Optional saturating error counter enabled by DEC_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trellis_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       y_in,
  input  logic             in_valid,
  output logic             x_out,
  output logic             x_valid,
  output logic             err,
  output logic [1:0]       est_state,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] c_ST_00 = 2'b00;
  localparam logic [1:0] c_ST_10 = 2'b10;
  localparam logic [1:0] c_ST_11 = 2'b11;

  logic [1:0] r_est;
  logic [1:0] r_prev_y;
  logic       r_have_prev;
  logic       r_x_out;
  logic       r_x_valid;
  logic       r_err;

  logic       w_ok;
  logic       w_bit;
  logic [1:0] w_next_e;
  logic       w_decode;
  logic       w_dec_err;

  // Decode the pending symbol; only state 10 needs the look-ahead symbol.
  always_comb begin
    w_ok     = 1'b0;
    w_bit    = 1'b0;
    w_next_e = c_ST_00;
    case (r_est)
      c_ST_00: begin
        if (r_prev_y == 2'b10) begin
          w_ok     = 1'b1;
          w_bit    = 1'b0;
          w_next_e = c_ST_10;
        end else if (r_prev_y == 2'b11) begin
          w_ok     = 1'b1;
          w_bit    = 1'b1;
          w_next_e = c_ST_00;
        end
      end
      c_ST_11: begin
        if (r_prev_y == 2'b11) begin
          w_ok     = 1'b1;
          w_bit    = 1'b0;
          w_next_e = c_ST_10;
        end else if (r_prev_y == 2'b01) begin
          w_ok     = 1'b1;
          w_bit    = 1'b1;
          w_next_e = c_ST_11;
        end
      end
      c_ST_10: begin
        if ((r_prev_y == 2'b10) && (y_in != 2'b00)) begin
          w_ok     = 1'b1;
          w_bit    = (y_in != 2'b10);
          w_next_e = (y_in != 2'b10) ? c_ST_11 : c_ST_10;
        end
      end
      default: begin
        w_ok = 1'b0;
      end
    endcase
  end

  assign w_decode  = in_valid && r_have_prev;
  assign w_dec_err = w_decode && !w_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_est       <= c_ST_00;
      r_prev_y    <= 2'b00;
      r_have_prev <= 1'b0;
      r_x_out     <= 1'b0;
      r_x_valid   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_x_valid <= 1'b0;
      r_err     <= w_dec_err;
      if (in_valid) begin
        r_prev_y    <= y_in;
        r_have_prev <= 1'b1;
      end
      if (w_decode) begin
        if (w_ok) begin
          r_x_out   <= w_bit;
          r_x_valid <= 1'b1;
          r_est     <= w_next_e;
        end else begin
          // Restart as if the incoming symbol were the first after reset.
          r_est <= c_ST_00;
        end
      end
    end
  end

`ifdef DEC_ERRCNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_dec_err && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

  assign x_out     = r_x_out;
  assign x_valid   = r_x_valid;
  assign err       = r_err;
  assign est_state = r_est;

endmodule

`default_nettype wire
